uart_tx_feeder: RTL and testbench
=================================

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, FIFO depth in bytes (power of 2, minimum 2).
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port wr_en, input, 1, push request for wr_data.
REQ-005 The block SHALL have port wr_data, input, 8, byte to queue.
REQ-006 The block SHALL have port flush, input, 1, discard all queued bytes.
REQ-007 The block SHALL have port full, output, 1, FIFO holds DEPTH bytes.
REQ-008 The block SHALL have port empty, output, 1, FIFO holds 0 bytes.
REQ-009 The block SHALL have port count, output, log2(DEPTH)+1, bytes queued.
REQ-010 The block SHALL have port overflow, output, 1, sticky flag for a write attempted while full.
REQ-011 The block SHALL have port tx_start, output, 1, one-cycle launch pulse to the UART transmitter.
REQ-012 The block SHALL have port tx_data, output, 8, byte presented to the transmitter.
REQ-013 The block SHALL have port tx_active, input, 1, transmitter busy level.
REQ-014 The block SHALL have port tx_done, input, 1, transmitter completion level (high for 1 or more cycles per byte).
REQ-015 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-016 FIFO SHALL be a circular buffer; read/write pointers wrap modulo DEPTH.
REQ-017 Write SHALL be accepted iff wr_en=1, full=0, flush=0; no same-cycle bypass when full.
REQ-018 wr_en=1 with full=1 SHALL set overflow; the byte is dropped; overflow clears only on rst.
REQ-019 flush=1 SHALL zero count and both pointers next cycle, discard a same-cycle write, suppress a same-cycle pop, and not alter FSM state or tx_data.
REQ-020 Simultaneous accepted write and pop SHALL leave count unchanged.
REQ-021 full/empty/count SHALL be registered-consistent: a write to an empty FIFO deasserts empty on the next cycle.
REQ-022 FSM states SHALL be IDLE, LOAD, START, WAIT_DONE, GAP.
REQ-023 IDLE: if empty=0 and flush=0, pop head into tx_data and go to LOAD; else stay.
REQ-024 LOAD: hold tx_data; go to START unconditionally.
REQ-025 START: tx_start=1 for exactly this cycle; go to WAIT_DONE.
REQ-026 WAIT_DONE: go to GAP on rising edge of tx_done (tx_done=1, previous-cycle tx_done=0); else stay.
REQ-027 GAP: go to IDLE when tx_done=0 and tx_active=0; else stay.
REQ-028 tx_data SHALL remain stable from LOAD until the next pop.
REQ-029 tx_start SHALL never assert outside START; at most one pulse per popped byte.
REQ-030 Latency: write into empty FIFO with FSM in IDLE at cycle N SHALL give tx_start=1 at cycle N+3.
REQ-031 Back-to-back bytes SHALL be popped in write order with no loss while count>0.
REQ-032 Any unused state encoding SHALL return to IDLE next cycle.

Reset
REQ-033 rst=1 SHALL immediately force: state IDLE, pointers 0, count 0, empty=1, full=0, overflow=0, tx_start=0, tx_data=8'h00, busy=0, tx_done edge register 0.
REQ-034 Reset mid-transfer SHALL discard the in-flight byte; no tx_start until a new write after rst deasserts.

Verification
REQ-035 Single byte: write 8'hA5 at cycle 0 -> tx_start pulse at cycle 3, tx_data=8'hA5; tx_done high 2 cycles -> one pulse only, busy low after tx_done and tx_active fall.
REQ-036 Fill/overflow: DEPTH=8, 9 writes while transmitter stalled -> full=1, count=8, overflow=1, 9th byte absent from output order.
REQ-037 Order/wrap: stream 20 bytes 8'h00..8'h13 with writes interleaved -> tx_data sequence 8'h00..8'h13 exactly, pointers wrapped twice.
REQ-038 Flush: 5 queued, byte in WAIT_DONE, flush=1 with wr_en=1 -> count=0 next cycle, in-flight byte completes, no further tx_start.
REQ-039 Async reset: assert rst in WAIT_DONE between clock edges -> outputs reach reset values before next edge; no tx_start after release until new write.
REQ-040 Level tx_done held high 10 cycles -> exactly one WAIT_DONE exit, FSM waits in GAP until tx_done=0 and tx_active=0.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter one byte at a time through a 5-state launch FSM.
// A write into an empty FIFO with the FSM idle produces tx_start three cycles later.
module uart_tx_feeder #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_active,
  input  logic                     tx_done,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            done_prev_q, done_prev_d;
  logic [7:0]      mem_q [DEPTH];

  logic push;
  logic pop;
  logic done_rise;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign tx_data   = tx_data_q;
  assign done_rise = tx_done & ~done_prev_q;

  // Flush blocks both sides of the FIFO in the cycle it is asserted.
  assign push = wr_en & ~full & ~flush;
  assign pop  = (state_q == IDLE) & ~empty & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (wr_en & full);
    tx_data_d   = tx_data_q;
    done_prev_d = tx_done;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        tx_data_d = mem_q[rd_ptr_q];
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pop) state_d = LOAD;
      LOAD:      state_d = START;
      START:     state_d = WAIT_DONE;
      WAIT_DONE: if (done_rise) state_d = GAP;
      GAP:       if (!tx_done && !tx_active) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_start = (state_q == START);
    busy     = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      tx_data_q   <= tx_data_d;
      done_prev_q <= done_prev_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: latency, fill/overflow, ordering with wrap, flush, async reset, level tx_done.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_active;
  logic       tx_done;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  int done_cnt = 0;
  logic [7:0] seen [$];

  uart_tx_feeder #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_start(tx_start), .tx_data(tx_data), .tx_active(tx_active),
    .tx_done(tx_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      pulses = pulses + 1;
      seen.push_back(tx_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulses   = 0;
    done_cnt = 0;
    seen.delete();
  endtask

  task automatic wait_pulse(input int n);
    int t = 0;
    while (pulses < n && t < 40) begin
      tick();
      t++;
    end
    chk("pulse_wait", 32'(pulses >= n), 32'd1);
  endtask

  // Acts as the transmitter for one launched byte: busy, a 2-cycle done, then idle.
  task automatic complete_byte();
    int t = 0;
    while (pulses <= done_cnt && t < 40) begin
      tick();
      t++;
    end
    chk("start_seen", 32'(pulses > done_cnt), 32'd1);
    tx_active = 1'b1;
    tick();
    tx_done = 1'b1;
    tick();
    tick();
    tx_done   = 1'b0;
    tx_active = 1'b0;
    tick();
    tick();
    done_cnt++;
  endtask

  initial begin
    int k;
    int p0;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    tx_active = 1'b0; tx_done = 1'b0;
    tick();
    tick();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Single byte, cycle-exact latency
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("c1_empty", empty, 0);
    chk("c1_count", count, 1);
    chk("c1_busy", busy, 0);
    tick();
    chk("c2_busy", busy, 1);
    chk("c2_tx_start", tx_start, 0);
    chk("c2_tx_data", tx_data, 8'hA5);
    chk("c2_count", count, 0);
    tick();
    chk("c3_tx_start", tx_start, 1);
    chk("c3_tx_data", tx_data, 8'hA5);
    tick();
    chk("c4_tx_start", tx_start, 0);
    tx_active = 1'b1; tx_done = 1'b1;
    tick();
    tick();
    tx_done = 1'b0; tx_active = 1'b0;
    chk("gap_busy", busy, 1);
    tick();
    chk("idle_busy", busy, 0);
    tick(); tick(); tick();
    chk("single_pulses", pulses, 1);
    chk("single_data", tx_data, 8'hA5);

    // Fill and overflow with the transmitter stalled on an earlier byte
    do_reset();
    wr(8'h11);
    wait_pulse(1);
    tx_active = 1'b1;
    for (int i = 0; i < 9; i++) wr(8'h20 + 8'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    chk("fill_overflow", overflow, 1);
    chk("fill_busy", busy, 1);
    for (int i = 0; i < 9; i++) complete_byte();
    tick(); tick(); tick();
    chk("fill_npulses", pulses, 9);
    chk("fill_first", seen[0], 8'h11);
    for (int i = 0; i < 8; i++) chk("fill_order", seen[i+1], 8'h20 + 8'(i));
    chk("fill_drained", empty, 1);
    chk("ovf_sticky", overflow, 1);
    do_reset();
    chk("ovf_cleared", overflow, 0);

    // Ordered stream of 20 bytes, pointers wrap twice
    for (int i = 0; i < 5; i++) wr(8'(i));
    k = 5;
    for (int j = 0; j < 20; j++) begin
      complete_byte();
      if (k < 20) begin
        wr(8'(k));
        k++;
      end
    end
    tick(); tick(); tick();
    chk("stream_npulses", pulses, 20);
    for (int i = 0; i < 20; i++) chk("stream_order", seen[i], 8'(i));
    chk("stream_empty", empty, 1);
    chk("stream_idle", busy, 0);

    // Flush while a byte is in WAIT_DONE
    do_reset();
    for (int i = 0; i < 6; i++) wr(8'h30 + 8'(i));
    chk("flush_pre_count", count, 5);
    chk("flush_pre_busy", busy, 1);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_tx_data", tx_data, 8'h30);
    chk("flush_busy", busy, 1);
    chk("flush_no_ovf", overflow, 0);
    complete_byte();
    repeat (10) tick();
    chk("flush_pulses", pulses, 1);
    chk("flush_idle", busy, 0);
    chk("flush_inflight", seen[0], 8'h30);

    // Asynchronous reset between edges while waiting for done
    do_reset();
    wr(8'h42);
    wait_pulse(1);
    tx_active = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_count", count, 0);
    chk("arst_tx_data", tx_data, 8'h00);
    chk("arst_tx_start", tx_start, 0);
    chk("arst_empty", empty, 1);
    tick();
    rst = 1'b0; tx_active = 1'b0;
    p0 = pulses;
    repeat (10) tick();
    chk("arst_quiet", pulses, p0);
    pulses = 0; done_cnt = 0; seen.delete();
    wr(8'h43);
    complete_byte();
    tick();
    chk("arst_new_pulses", pulses, 1);
    chk("arst_new_data", seen[0], 8'h43);

    // Level tx_done held for 10 cycles with a second byte queued
    do_reset();
    wr(8'h55);
    wr(8'h56);
    wait_pulse(1);
    tx_active = 1'b1;
    tick();
    tx_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("level_busy", busy, 1);
    end
    chk("level_pulses", pulses, 1);
    tx_done = 1'b0;
    repeat (3) tick();
    chk("gap_hold_busy", busy, 1);
    chk("gap_hold_pulses", pulses, 1);
    tx_active = 1'b0;
    tick();
    chk("gap_exit_idle", busy, 0);
    done_cnt = 1;
    complete_byte();
    tick();
    chk("level_second_pulses", pulses, 2);
    chk("level_second_data", seen[1], 8'h56);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
